hazard_ctrl: RTL and testbench

- Stall/flush sequencer for the 5-stage stalling (no-forwarding) RV32I pipeline.
- Keeps a per-register scoreboard of in-flight writes and holds IF/ID while a source register is pending.
- Inserts bubbles into the ID/EX register and flushes younger instructions on an EX-stage redirect.
- Sits beside the decode stage and drives the enable/clear inputs of the PC, IF/ID and ID/EX registers.

---
 rtl/hazard_pkg.sv | 35 +++
 rtl/hazard_ctrl_if.sv | 31 +++
 rtl/hazard_scoreboard.sv | 44 ++++
 rtl/hazard_ctrl.sv | 96 +++++++++
 tb/tb_hazard_ctrl.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the stall/flush sequencer.
// Pure declarations: no logic, no latency, no backpressure.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_t;

    localparam int NREG_DEF   = 32;
    localparam int WB_LAT_DEF = 3;

    // Pipeline-register control word driven by the priority mux.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_bubble;
    } hz_ctl_t;

    // Bubble encoding: ID/EX loads a NOP while the front end holds.
    localparam hz_ctl_t CTL_BUBBLE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                       idex_en: 1'b1, idex_bubble: 1'b1};
    localparam hz_ctl_t CTL_RUN    = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                       idex_en: 1'b1, idex_bubble: 1'b0};
    localparam hz_ctl_t CTL_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                       idex_en: 1'b0, idex_bubble: 1'b0};
    localparam hz_ctl_t CTL_REDIR  = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
                                       idex_en: 1'b1, idex_bubble: 1'b1};
    localparam hz_ctl_t CTL_RESET  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
                                       idex_en: 1'b1, idex_bubble: 1'b1};

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side hazard bundle: ID operand info in, pipeline register controls out.
// Wires only: zero latency; master is the decode stage, slave is hazard_ctrl.
interface hazard_ctrl_if;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_rd_wren;
    logic       ex_redirect;
    logic       mem_stall;
    logic       pc_en;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_en;
    logic       idex_bubble;
    logic [1:0] hz_state;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_wren, ex_redirect, mem_stall,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, hz_state
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_wren, ex_redirect, mem_stall,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, hz_state
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown of in-flight writes with two combinational pending lookups.
// Lookups are zero latency; hold freezes every counter (whole-pipe memory stall).
module hazard_scoreboard #(
    parameter int NREG   = 32,
    parameter int WB_LAT = 3,
    parameter int CNT_W  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       set_en,
    input  logic [4:0] set_idx,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       rs1_pend,
    output logic       rs2_pend
);

    logic [CNT_W-1:0] cnt [1:NREG-1];

    // A set beats the decrement on the same register; x0 has no counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 1; r < NREG; r++) cnt[r] <= '0;
        end else if (!hold) begin
            for (int r = 1; r < NREG; r++) begin
                if (set_en && set_idx == 5'(r))
                    cnt[r] <= CNT_W'(WB_LAT);
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        rs1_pend = 1'b0;
        rs2_pend = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            if (rs1 == 5'(r) && cnt[r] != '0) rs1_pend = 1'b1;
            if (rs2 == 5'(r) && cnt[r] != '0) rs2_pend = 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the stalling RV32I pipe; HAZARD_CTRL_PERF_EN adds perf counters.
// Controls are combinational from scoreboard/inputs; priority mem_stall > ex_redirect > RAW.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int WB_LAT = WB_LAT_DEF,
    parameter int CNT_W  = 2
) (
    input  logic        clk,
    input  logic        rst,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    if ((1 << CNT_W) <= WB_LAT) begin : g_cnt_w_check
        $error("CNT_W too narrow for WB_LAT");
    end

    hz_state_t state_q, state_d;
    hz_ctl_t   ctl;
    logic      rs1_pend, rs2_pend;
    logic      raw;
    logic      issue;

    assign raw = hz.id_valid & ((hz.id_rs1_used & rs1_pend) |
                                (hz.id_rs2_used & rs2_pend));

    assign issue = hz.id_valid & ~raw & ~hz.ex_redirect & ~hz.mem_stall &
                   hz.id_rd_wren & (hz.id_rd != 5'd0);

    hazard_scoreboard #(
        .NREG   (NREG),
        .WB_LAT (WB_LAT),
        .CNT_W  (CNT_W)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .hold     (hz.mem_stall),
        .set_en   (issue),
        .set_idx  (hz.id_rd),
        .rs1      (hz.id_rs1),
        .rs2      (hz.id_rs2),
        .rs1_pend (rs1_pend),
        .rs2_pend (rs2_pend)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!hz.mem_stall) begin
            if (hz.ex_redirect) state_d = FLUSH;
            else if (raw)       state_d = STALL;
            else                state_d = RUN;
        end
    end

    // Reset forces a flushing, bubbling front end while the pipe registers clear.
    always_comb begin
        ctl = CTL_RUN;
        if (!rst)                ctl = CTL_RESET;
        else if (hz.mem_stall)   ctl = CTL_FREEZE;
        else if (hz.ex_redirect) ctl = CTL_REDIR;
        else if (raw)            ctl = CTL_BUBBLE;
    end

    assign hz.pc_en       = ctl.pc_en;
    assign hz.ifid_en     = ctl.ifid_en;
    assign hz.ifid_flush  = ctl.ifid_flush;
    assign hz.idex_en     = ctl.idex_en;
    assign hz.idex_bubble = ctl.idex_bubble;
    assign hz.hz_state    = state_q;

`ifdef HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (raw && !hz.mem_stall && !hz.ex_redirect)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (hz.ex_redirect && !hz.mem_stall)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares each cycle's controls and state.
module tb_hazard_ctrl;

    localparam logic [4:0] O_RUN = 5'b11010;  // {pc,ifid,flush,idex,bubble}
    localparam logic [4:0] O_RAW = 5'b00011;
    localparam logic [4:0] O_RED = 5'b11111;
    localparam logic [4:0] O_MEM = 5'b00000;
    localparam logic [4:0] O_RST = 5'b00111;
    localparam logic [1:0] S_RUN = 2'd0, S_STL = 2'd1, S_FLS = 2'd2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if hz();

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
    hazard_ctrl dut (.clk(clk), .rst(rst), .hz(hz),
                     .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt));
`else
    hazard_ctrl dut (.clk(clk), .rst(rst), .hz(hz));
`endif

    logic [6:0] exp_q [$];
    string      nm_q  [$];
    int n_vec = 0;
    int n_err = 0;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [6:0] e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            a  = {hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_en, hz.idex_bubble, hz.hz_state};
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s: got ctl=%b st=%0d, want ctl=%b st=%0d",
                         nm, a[6:2], a[1:0], e[6:2], e[1:0]);
            end
        end
    end

    task automatic cyc(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic redir, input logic ms,
                       input logic [4:0] o, input logic [1:0] st, input string nm);
        @(posedge clk); #1;
        hz.id_valid = v;  hz.id_rs1 = r1; hz.id_rs1_used = u1;
        hz.id_rs2 = r2;   hz.id_rs2_used = u2;
        hz.id_rd = rd;    hz.id_rd_wren = wr;
        hz.ex_redirect = redir; hz.mem_stall = ms;
        exp_q.push_back({o, st});
        nm_q.push_back(nm);
    endtask

    task automatic ins(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                       input logic u2, input logic [4:0] rd, input logic wr,
                       input logic [4:0] o, input logic [1:0] st, input string nm);
        cyc(1'b1, r1, u1, r2, u2, rd, wr, 1'b0, 1'b0, o, st, nm);
    endtask

    task automatic idle(input logic [1:0] st, input string nm);
        cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN, st, nm);
    endtask

    task automatic rcyc(input logic r, input logic [4:0] o, input logic [1:0] st,
                        input string nm);
        @(posedge clk); #1;
        rst = r;
        exp_q.push_back({o, st});
        nm_q.push_back(nm);
    endtask

    initial begin
        hz.id_valid = 1'b0; hz.id_rs1 = '0; hz.id_rs1_used = 1'b0;
        hz.id_rs2 = '0; hz.id_rs2_used = 1'b0; hz.id_rd = '0; hz.id_rd_wren = 1'b0;
        hz.ex_redirect = 1'b0; hz.mem_stall = 1'b0;

        // Reset held for 3 cycles, then released
        for (int i = 0; i < 3; i++) rcyc(1'b0, O_RST, S_RUN, "reset_hold");
        rcyc(1'b1, O_RUN, S_RUN, "reset_release");
        for (int i = 0; i < 16; i++)
            ins(5'(2*i+1), 1'b1, 5'(2*i+2), 1'b1, 5'd0, 1'b0, O_RUN, S_RUN, "cnt_clear");

        // Back-to-back RAW on x5: 3 stalls
        ins(5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, O_RUN, S_RUN, "b2b_prod");
        ins(5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, O_RAW, S_RUN, "b2b_stall1");
        ins(5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, O_RAW, S_STL, "b2b_stall2");
        ins(5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, O_RAW, S_STL, "b2b_stall3");
        ins(5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, O_RUN, S_STL, "b2b_issue");
        for (int i = 0; i < 3; i++) idle(S_RUN, "b2b_drain");

        // Distance-2 dependence through rs2: 2 stalls
        ins(5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, O_RUN, S_RUN, "d2_prod");
        ins(5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, O_RUN, S_RUN, "d2_indep");
        ins(5'd3, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, O_RAW, S_RUN, "d2_stall1");
        ins(5'd3, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, O_RAW, S_STL, "d2_stall2");
        ins(5'd3, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, O_RUN, S_STL, "d2_issue");

        // x0 writer/reader and an unused source never stall
        ins(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, O_RUN, S_RUN, "x0_write");
        ins(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, O_RUN, S_RUN, "x0_read");
        ins(5'd0, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, O_RUN, S_RUN, "unused_prod");
        ins(5'd10, 1'b0, 5'd10, 1'b0, 5'd0, 1'b0, O_RUN, S_RUN, "unused_read");
        for (int i = 0; i < 3; i++) idle(S_RUN, "unused_drain");

        // Redirect on the 2nd stall cycle; x5 keeps draining, x6 not set
        ins(5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, O_RUN, S_RUN, "rd_prod");
        ins(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, O_RAW, S_RUN, "rd_stall1");
        cyc(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, O_RED, S_STL, "rd_redirect");
        ins(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, O_RAW, S_FLS, "rd_flush_state");
        ins(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, O_RUN, S_STL, "rd_x5_drained");
        ins(5'd6, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, O_RUN, S_RUN, "rd_no_set_x6");

        // mem_stall freeze with cnt[x5]=2, including a masked redirect
        ins(5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, O_RUN, S_RUN, "ms_prod");
        ins(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, O_RAW, S_RUN, "ms_stall1");
        cyc(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_MEM, S_STL, "ms_freeze1");
        cyc(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_MEM, S_STL, "ms_freeze2");
        cyc(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_MEM, S_STL, "ms_freeze_redir");
        cyc(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_MEM, S_STL, "ms_freeze4");
        ins(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, O_RAW, S_STL, "ms_after1");
        ins(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, O_RAW, S_STL, "ms_after2");
        ins(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, O_RUN, S_STL, "ms_issue");
        idle(S_RUN, "ms_idle");

        // Re-set x9 while its counter is 1: full 3-cycle stall follows
        ins(5'd0, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, O_RUN, S_RUN, "reset9_prod1");
        idle(S_RUN, "reset9_gap1");
        idle(S_RUN, "reset9_gap2");
        ins(5'd0, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, O_RUN, S_RUN, "reset9_prod2");
        ins(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, O_RAW, S_RUN, "reset9_stall1");
        ins(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, O_RAW, S_STL, "reset9_stall2");
        ins(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, O_RAW, S_STL, "reset9_stall3");
        ins(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, O_RUN, S_STL, "reset9_issue");

        // Reset mid-stall clears the scoreboard at once
        ins(5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, O_RUN, S_RUN, "rm_prod");
        ins(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, O_RAW, S_RUN, "rm_stall");
        rcyc(1'b0, O_RST, S_RUN, "rm_reset");
        rcyc(1'b1, O_RUN, S_RUN, "rm_release");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
